// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes and arbiter FSM state encoding shared by the ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: chooses which requester wins the shared ALU.
// ALU_ARB_RR_EN defined: round-robin on a tie (winner is the one not granted last);
// undefined: fixed priority, requester 0 always wins a tie and last is unused.
module alu_arb_pick (
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic gnt
);

`ifdef ALU_ARB_RR_EN
    // requester 1 wins when alone, or on a tie when requester 0 was granted last
    always_comb gnt = v1 & (~v0 | ~last);
`else
    logic unused_last;
    assign unused_last = last;
    // requester 1 wins only when requester 0 is not asking
    always_comb gnt = v1 & ~v0;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// Each operation runs IDLE (accept) -> EXEC (drive ALU, capture) -> RESP (hold result).
// Define ALU_ARB_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    state_t              state_q, state_d;
    logic                id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                zero_q, zero_d;
    logic                last, gnt, idle, exec, resp, accept, rsp_hs;

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;
    assign last = last_q;
    // remember who was granted most recently; reset value 1 lets requester 0 win first
    always_comb last_d = accept ? gnt : last_q;
    // last-grant register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
`else
    assign last = 1'b1;
`endif

    alu_arb_pick u_pick (
        .v0   (req0_valid),
        .v1   (req1_valid),
        .last (last),
        .gnt  (gnt)
    );

    // handshakes, ALU drive and next-state; readies are gated by rst_n so reset clears them at once
    always_comb begin
        idle       = rst_n && state_q == S_IDLE;
        exec       = state_q == S_EXEC;
        resp       = state_q == S_RESP;
        req0_ready = idle & req0_valid & ~gnt;
        req1_ready = idle & req1_valid & gnt;
        accept     = req0_ready | req1_ready;
        rsp0_valid = resp & ~id_q;
        rsp1_valid = resp & id_q;
        rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        rsp_result = res_q;
        rsp_zero   = zero_q;
        alu_a      = exec ? a_q : '0;
        alu_b      = exec ? b_q : '0;
        alu_ctrl   = exec ? ctrl_q : CTRL_W'(ALU_ADD);
        state_d    = accept ? S_EXEC : exec ? S_RESP : rsp_hs ? S_IDLE : state_q;
        id_d       = accept ? gnt : id_q;
        a_d        = accept ? (gnt ? req1_a : req0_a) : a_q;
        b_d        = accept ? (gnt ? req1_b : req0_b) : b_q;
        ctrl_d     = accept ? (gnt ? req1_ctrl : req0_ctrl) : ctrl_q;
        res_d      = exec ? alu_result : res_q;
        zero_d     = exec ? alu_zero : zero_q;
    end

    // state, latched request and captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a protocol-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]  req0_ctrl = 0, req1_ctrl = 0;
    logic        rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_zero, alu_zero;
    logic [3:0]  alu_ctrl;

    int n_cmp = 0, n_bad = 0;
    bit last_m = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            default:  return 32'h0;
        endcase
    endfunction

    // behavioural shared ALU answering in the same cycle
    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = alu_result == 32'h0;

    // arbitration rule: -1 none, else winning requester id
    function automatic int win(input bit v0, input bit v1, input bit last);
        if (!v0 && !v1) return -1;
        if (!v1) return 0;
        if (!v0) return 1;
`ifdef ALU_ARB_RR_EN
        return last ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1; last_m = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1;
        #1;
        n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero}); end
        n_cmp++; if (rsp_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", rsp_result); end
        n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== 68'h0) begin n_bad++; $display("FAIL reset_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_ctrl); end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); rst_n = 1; last_m = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_ctrl = ALU_SUB; rsp0_ready = 1;
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready}); end
        last_m = 1'b0;
        @(negedge clk); req0_valid = 0; #1;
        n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, ALU_SUB}) begin n_bad++; $display("FAIL single_exec_alu: got %h/%h/%h want 5/3/1", alu_a, alu_b, alu_ctrl); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_rsp: got %b want 0", rsp0_valid); end
        @(negedge clk); #1;
        n_cmp++; if ({rsp0_valid, rsp1_valid, rsp_zero} !== 3'b100) begin n_bad++; $display("FAIL single_rsp_flags: got %b want 100", {rsp0_valid, rsp1_valid, rsp_zero}); end
        n_cmp++; if (rsp_result !== 32'd2) begin n_bad++; $display("FAIL single_result: got %h want 2", rsp_result); end
        @(negedge clk); #1;
        n_cmp++; if ({rsp0_valid, alu_a, alu_b, alu_ctrl} !== 69'h0) begin n_bad++; $display("FAIL single_after: got v=%b alu=%h/%h/%h want 0", rsp0_valid, alu_a, alu_b, alu_ctrl); end
        rsp0_ready = 0;
    endtask

    task automatic test_arb();
        int w;
        do_reset();
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 10; req0_b = 1; req0_ctrl = ALU_ADD; req1_a = 20; req1_b = 2; req1_ctrl = ALU_ADD;
        for (int k = 0; k < 4; k++) begin
            #1;
            w = win(1, 1, last_m);
            n_cmp++; if ({req1_ready, req0_ready} !== (w == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL arb_grant%0d: got %b want winner %0d", k, {req1_ready, req0_ready}, w); end
            last_m = (w == 1);
            @(negedge clk); #1;
            n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL arb_busy%0d: got %b want 00", k, {req1_ready, req0_ready}); end
            @(negedge clk); #1;
            n_cmp++; if ({rsp1_valid, rsp0_valid, rsp_result} !== (w == 1 ? {2'b10, 32'd22} : {2'b01, 32'd11})) begin n_bad++; $display("FAIL arb_rsp%0d: got %b %h for winner %0d", k, {rsp1_valid, rsp0_valid}, rsp_result, w); end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        req1_valid = 1; req1_a = 7; req1_b = 7; req1_ctrl = ALU_SUB; rsp1_ready = 0;
        #1;
        n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_bad++; $display("FAIL hold_accept: got %b want 10", {req1_ready, req0_ready}); end
        last_m = 1'b1;
        @(negedge clk);
        req1_valid = 0; req0_valid = 1; req0_a = 9; req0_b = 4; req0_ctrl = ALU_ADD;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if ({rsp1_valid, rsp0_valid, rsp_result, rsp_zero, req0_ready} !== {2'b10, 32'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL hold_cyc%0d: got v1=%b v0=%b res=%h z=%b r0=%b want 1 0 0 1 0", k, rsp1_valid, rsp0_valid, rsp_result, rsp_zero, req0_ready); end
            @(negedge clk);
        end
        rsp1_ready = 1; rsp0_ready = 1;
        @(negedge clk); rsp1_ready = 0; #1;
        n_cmp++; if ({req0_ready, rsp1_valid} !== 2'b10) begin n_bad++; $display("FAIL hold_waiter: got r0=%b v1=%b want 1 0", req0_ready, rsp1_valid); end
        last_m = 1'b0;
        @(negedge clk); req0_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if ({rsp0_valid, rsp_result} !== {1'b1, 32'd13}) begin n_bad++; $display("FAIL hold_waiter_rsp: got v0=%b res=%h want 1 d", rsp0_valid, rsp_result); end
        @(negedge clk); rsp0_ready = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rsp0_ready = 1; req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_ctrl = ALU_ADD;
        #1;
        n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept1: got %b want 1", req0_ready); end
        @(negedge clk);
        req0_a = 6; req0_b = 3; req0_ctrl = ALU_XOR; #1;
        n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_exec_ready: got %b want 0", req0_ready); end
        @(negedge clk); #1;
        n_cmp++; if ({rsp0_valid, rsp_result, rsp_zero, req0_ready} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL b2b_rsp1: got v=%b res=%h z=%b r=%b want 1 0 1 0", rsp0_valid, rsp_result, rsp_zero, req0_ready); end
        @(negedge clk); #1;
        n_cmp++; if ({req0_ready, rsp0_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept2: got r=%b v=%b want 1 0", req0_ready, rsp0_valid); end
        @(negedge clk); req0_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if ({rsp0_valid, rsp_result, rsp_zero} !== {1'b1, 32'd5, 1'b0}) begin n_bad++; $display("FAIL b2b_rsp2: got v=%b res=%h z=%b want 1 5 0", rsp0_valid, rsp_result, rsp_zero); end
        @(negedge clk); rsp0_ready = 0; last_m = 1'b0;
    endtask

    task automatic test_ignore();
        @(negedge clk);
        req1_valid = 1; req1_a = 3; req1_b = 10; req1_ctrl = ALU_SLT; rsp1_ready = 0; rsp0_ready = 1;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL ign_accept: got %b want 1", req1_ready); end
        last_m = 1'b1;
        @(negedge clk); req1_valid = 0;
        @(negedge clk); #1;
        n_cmp++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin n_bad++; $display("FAIL ign_pulse: got %b want 10", {rsp1_valid, rsp0_valid}); end
        @(negedge clk); rsp0_ready = 0; #1;
        n_cmp++; if ({rsp1_valid, rsp_result} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL ign_held: got v1=%b res=%h want 1 1", rsp1_valid, rsp_result); end
        rsp1_ready = 1;
        @(negedge clk); rsp1_ready = 0; #1;
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_bad++; $display("FAIL ign_done: got %b want 0", rsp1_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_ctrl = ALU_ADD; rsp0_ready = 1;
        @(negedge clk); req0_valid = 0; #1;
        n_cmp++; if (alu_a !== 32'd1) begin n_bad++; $display("FAIL rmid_exec: got %h want 1", alu_a); end
        #1 rst_n = 0; #1;
        n_cmp++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_result, alu_a, alu_b, alu_ctrl} !== 105'h0) begin n_bad++; $display("FAIL rmid_async: got rv=%b res=%h alu=%h/%h/%h want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero}, rsp_result, alu_a, alu_b, alu_ctrl); end
        @(negedge clk); rst_n = 1; last_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_norsp%0d: got %b want 00", k, {rsp0_valid, rsp1_valid}); end
            @(negedge clk);
        end
        rsp0_ready = 0;
    endtask

    task automatic test_random();
        bit          hold [2];
        logic [31:0] pa [2], pb [2];
        logic [3:0]  pc [2];
        bit          busy = 0, ev;
        int          acc_c = 0, tid = 0, w;
        logic [31:0] texp = 0;
        do_reset();
        hold[0] = 0; hold[1] = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int n = 0; n < 2; n++)
                if (!hold[n] && $urandom_range(1) == 1) begin
                    hold[n] = 1; pa[n] = $urandom; pb[n] = ($urandom_range(3) == 0) ? pa[n] : $urandom; pc[n] = 4'($urandom_range(9));
                end
            req0_valid = hold[0]; req0_a = pa[0]; req0_b = pb[0]; req0_ctrl = pc[0];
            req1_valid = hold[1]; req1_a = pa[1]; req1_b = pb[1]; req1_ctrl = pc[1];
            rsp0_ready = 1'($urandom_range(1)); rsp1_ready = 1'($urandom_range(1));
            #1;
            w = busy ? -1 : win(hold[0], hold[1], last_m);
            ev = busy && k >= acc_c + 2;
            n_cmp++; if ({req1_ready, req0_ready} !== {w == 1, w == 0}) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want winner %0d", k, {req1_ready, req0_ready}, w); end
            n_cmp++; if ({rsp1_valid, rsp0_valid} !== {ev && tid == 1, ev && tid == 0}) begin n_bad++; $display("FAIL rnd_rspv@%0d: got %b want %b", k, {rsp1_valid, rsp0_valid}, {ev && tid == 1, ev && tid == 0}); end
            if (ev) begin
                n_cmp++; if ({rsp_result, rsp_zero} !== {texp, texp == 32'h0}) begin n_bad++; $display("FAIL rnd_result@%0d: got %h z=%b want %h", k, rsp_result, rsp_zero, texp); end
            end
            if (w >= 0) begin
                busy = 1; acc_c = k; tid = w; texp = alu_f(pa[w], pb[w], pc[w]); hold[w] = 0; last_m = (w == 1);
            end else if (ev && (tid == 1 ? rsp1_ready : rsp0_ready)) busy = 0;
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arb();
        test_hold();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CTRL_W, default 4, ALUControl code width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, requester N presents an operation.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each, arbiter accepts requester N this cycle.
REQ-007 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, DATA_W each, operands.
REQ-008 SHALL have ports req0_ctrl/req1_ctrl, input, CTRL_W each, ALUControl code.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid, output, 1 each, result available for requester N.
REQ-010 SHALL have ports rsp0_ready/rsp1_ready, input, 1 each, requester N consumes result.
REQ-011 SHALL have ports rsp_result (output, DATA_W) and rsp_zero (output, 1), shared by both responders.
REQ-012 SHALL have ports alu_a/alu_b (output, DATA_W) and alu_ctrl (output, CTRL_W) driving the shared combinational ALU.
REQ-013 SHALL have ports alu_result (input, DATA_W) and alu_zero (input, 1) returned by the ALU in the same cycle.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 SHALL, in IDLE, select a winner from the valid requesters and drive only the winner's reqN_ready high; no ready when no valid.
REQ-016 SHALL, on reqN_valid & reqN_ready, latch operands, ctrl and grant id, and go to EXEC next cycle.
REQ-017 SHALL, in EXEC, drive alu_a/alu_b/alu_ctrl from latched values, capture alu_result/alu_zero at cycle end, go to RESP.
REQ-018 SHALL, outside EXEC, drive alu_a=0, alu_b=0, alu_ctrl=4'b0000 (ADD).
REQ-019 SHALL, in RESP, hold rspN_valid high only for the granted id, with stable rsp_result/rsp_zero, until rspN_ready.
REQ-020 SHALL, on rspN_valid & rspN_ready, drop rspN_valid and return to IDLE next cycle; min 3 cycles per operation, accept-to-rsp_valid latency 2 cycles.
REQ-021 SHALL deassert both reqN_ready in EXEC and RESP; requests arriving then wait and are not lost.
REQ-022 SHALL ignore rspN_ready of the non-granted requester and any rspN_ready outside RESP.
REQ-023 SHALL pass result width unchanged (DATA_W); no sign or width conversion.

Reset
REQ-024 SHALL, on rst_n low, immediately force IDLE, all ready/valid outputs 0, rsp_result=0, rsp_zero=0, ALU outputs per REQ-018, last-grant=1.
REQ-025 SHALL discard any in-flight operation on reset mid-EXEC or mid-RESP; no response issued after release.
REQ-026 SHALL resume arbitration in the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with ALU_ARB_RR_EN defined, grant round-robin: on simultaneous valid, winner is the requester not granted last; last-grant updates on each accept.
REQ-028 SHALL, without ALU_ARB_RR_EN, use fixed priority: requester 0 always wins on simultaneous valid; last-grant register absent.

Structure
REQ-029 SHALL place the ALUControl code constants (ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SLT=0101, SLTU=0110, XOR=0111, SRL=1000, SRA=1001) and FSM state encodings in shared package alu_pkg.
REQ-030 SHALL implement winner selection in one sub-module alu_arb_pick (inputs valids + last-grant, output grant id), the FSM and registers in alu_arbiter.

Verification
REQ-031 SHALL cover: req0 alone, a=5, b=3, ctrl=SUB, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp_result=2, rsp_zero=0.
REQ-032 SHALL cover: both valid from reset, RR build -> req0 then req1 served; fixed build, req0 held valid -> req1 never granted while req0 valid.
REQ-033 SHALL cover: req1 a=7, b=7, ctrl=SUB, rsp1_ready low 5 cycles -> rsp1_valid held, rsp_result=0, rsp_zero=1 stable; req0 arriving meanwhile sees req0_ready=0.
REQ-034 SHALL cover: rst_n low during EXEC -> all outputs at reset values asynchronously; no rsp*_valid after release.
REQ-035 SHALL cover: back-to-back ops, a=0xFFFFFFFF, b=1, ADD -> rsp_result=0, rsp_zero=1; next op accepted the cycle after response handshake.
REQ-036 SHALL cover: rsp0_ready pulsed while rsp1 granted -> ignored, rsp1_valid unaffected.
